// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared serial bus: one-hot grants to NUM_MASTERS
// requesters, with grant-to-start and bus-hold watchdogs to recover stalled masters.
module bus_arbiter_rr #(
   parameter int unsigned NUM_MASTERS  = 4,
   parameter int unsigned ID_WIDTH     = 2,
   parameter int unsigned START_TO_LEN = 4,
   parameter int unsigned HOLD_TO_LEN  = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] m_request,
   input  logic                   b_bus_utilizing,
   input  logic                   slv_bsy,
   output logic [NUM_MASTERS-1:0] m_grant,
   output logic [ID_WIDTH-1:0]    grant_id,
   output logic                   arb_busy,
   output logic                   timeout
);

   localparam int unsigned CNT_W = (START_TO_LEN > HOLD_TO_LEN) ? START_TO_LEN : HOLD_TO_LEN;
   localparam int unsigned IDX_W = ID_WIDTH + 1;
   localparam logic [CNT_W-1:0] START_LIM = CNT_W'((2**START_TO_LEN) - 1);
   localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'((2**HOLD_TO_LEN) - 1);

   typedef enum logic [1:0] {IDLE, WAIT_START, BUSY, RELEASE} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0]    last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   timeout_q, timeout_d;
   logic                   busy_q, busy_d;

   logic                   found;
   logic [ID_WIDTH-1:0]    winner;
   logic [IDX_W-1:0]       idx;

   // Rotating search starting just after the last owner; one extra index bit
   // lets the wrap be done by a single conditional subtraction.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         idx = {1'b0, last_q} + IDX_W'(i);
         if (idx >= IDX_W'(NUM_MASTERS)) begin
            idx = idx - IDX_W'(NUM_MASTERS);
         end
         if (!found && m_request[idx[ID_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found && !slv_bsy && !b_bus_utilizing) begin
               grant_d    = NUM_MASTERS'(1) << winner;
               grant_id_d = winner;
               cnt_d      = '0;
               state_d    = WAIT_START;
            end
         end
         WAIT_START: begin
            // Reaching the limit means the pulse has already been issued.
            if (cnt_q == START_LIM) begin
               grant_d = '0;
               state_d = RELEASE;
            end else if (b_bus_utilizing) begin
               cnt_d   = '0;
               state_d = BUSY;
            end else if (!m_request[grant_id_q]) begin
               grant_d = '0;
               state_d = RELEASE;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               timeout_d = (cnt_d == START_LIM);
            end
         end
         BUSY: begin
            if (!b_bus_utilizing || (cnt_q == HOLD_LIM)) begin
               grant_d = '0;
               state_d = RELEASE;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               timeout_d = (cnt_d == HOLD_LIM);
            end
         end
         RELEASE: begin
            last_d  = grant_id_q;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         last_q     <= ID_WIDTH'(NUM_MASTERS - 1);
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
      end
   end

   assign m_grant  = grant_q;
   assign grant_id = grant_id_q;
   assign arb_busy = busy_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus randomized traffic, all
// checked every cycle against a tenure-level reference model.
module tb_bus_arbiter_rr;

   localparam int N         = 4;
   localparam int START_LIM = 15;
   localparam int HOLD_LIM  = 255;

   logic         clk = 1'b0;
   logic         rstn;
   logic [N-1:0] req;
   logic         ut;
   logic         sb;
   logic [N-1:0] m_grant;
   logic [1:0]   grant_id;
   logic         arb_busy;
   logic         timeout;

   always #5 clk = ~clk;

   bus_arbiter_rr #(
      .NUM_MASTERS (N),
      .ID_WIDTH    (2),
      .START_TO_LEN(4),
      .HOLD_TO_LEN (8)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .m_request      (req),
      .b_bus_utilizing(ut),
      .slv_bsy        (sb),
      .m_grant        (m_grant),
      .grant_id       (grant_id),
      .arb_busy       (arb_busy),
      .timeout        (timeout)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: who owns the bus, since which cycle, and whether the
   // owner has started using it; expected outputs follow from those facts.
   int cyc      = 0;
   int owner    = -1;
   int id_e     = 0;
   int last     = N - 1;
   int busy_e   = 0;
   int to_e     = 0;
   int rel_pend = 0;
   int t0       = 0;
   int used     = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] exp_grant();
      return (owner >= 0) ? (32'd1 << owner) : 32'd0;
   endfunction

   task automatic model_reset();
      owner = -1; id_e = 0; last = N - 1; busy_e = 0; to_e = 0; rel_pend = 0; used = 0;
   endtask

   task automatic model_drop();
      owner    = -1;
      rel_pend = 1;
   endtask

   task automatic model_edge();
      cyc++;
      to_e = 0;
      if (!rstn) begin
         model_reset();
      end else if (rel_pend != 0) begin
         rel_pend = 0;
         last     = id_e;
         busy_e   = 0;
      end else if (owner < 0) begin
         if (req != '0 && !sb && !ut) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (last + k) % N;
               if (owner < 0 && req[c]) owner = c;
            end
            id_e = owner; t0 = cyc; used = 0; busy_e = 1;
         end
      end else if (used == 0) begin
         if (cyc == t0 + START_LIM + 1) model_drop();
         else if (ut) begin used = 1; t0 = cyc; end
         else if (!req[owner]) model_drop();
         else if (cyc == t0 + START_LIM) to_e = 1;
      end else begin
         if (!ut || cyc == t0 + HOLD_LIM + 1) model_drop();
         else if (cyc == t0 + HOLD_LIM) to_e = 1;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_eq("grant",    32'(m_grant),  exp_grant());
      check_eq("grant_id", 32'(grant_id), 32'(id_e));
      check_eq("arb_busy", 32'(arb_busy), 32'(busy_e));
      check_eq("timeout",  32'(timeout),  32'(to_e));
   endtask

   task automatic do_reset();
      rstn = 1'b0; req = '0; ut = 1'b0; sb = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic wait_grant(input int budget, output int gid);
      gid = -1;
      for (int k = 0; k < budget; k++) begin
         step();
         if (m_grant != '0) begin
            gid = int'(grant_id);
            break;
         end
      end
      check_eq("grant_seen", 32'(|m_grant), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      int gid;
      int k;
      int drop_cyc;
      int order[5];
      int exp_order[5];
      int mode;
      int len;

      exp_order = '{0, 1, 2, 3, 0};

      // Reset state, asynchronous
      rstn = 1'b0; req = '0; ut = 1'b0; sb = 1'b0;
      #1;
      check_eq("rst_grant", 32'(m_grant),  32'd0);
      check_eq("rst_id",    32'(grant_id), 32'd0);
      check_eq("rst_busy",  32'(arb_busy), 32'd0);
      check_eq("rst_to",    32'(timeout),  32'd0);
      do_reset();

      // Single requester
      req = 4'b0100;
      step();
      check_eq("single_grant", 32'(m_grant),  32'b0100);
      check_eq("single_id",    32'(grant_id), 32'd2);
      ut = 1'b1;
      for (int i = 0; i < 10; i++) step();
      ut = 1'b0; req = '0;
      step();
      check_eq("single_drop", 32'(m_grant), 32'd0);
      step();
      check_eq("single_idle", 32'(arb_busy), 32'd0);

      // Round-robin fairness
      do_reset();
      req = '1;
      drop_cyc = -100;
      for (int t = 0; t < 5; t++) begin
         wait_grant(20, gid);
         order[t] = gid;
         if (t > 0) check_eq("rr_gap_ge2", 32'(cyc - drop_cyc >= 2), 32'd1);
         ut = 1'b1; step(); step();
         ut = 1'b0; step();
         drop_cyc = cyc;
      end
      for (int t = 0; t < 5; t++) check_eq("rr_order", 32'(order[t]), 32'(exp_order[t]));

      // Start timeout
      do_reset();
      req = 4'b0010;
      step();
      check_eq("sto_id", 32'(grant_id), 32'd1);
      req = 4'b0110;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (timeout) begin k = i; break; end
      end
      check_eq("sto_delay", 32'(k), 32'(START_LIM));
      step();
      check_eq("sto_clear", 32'(m_grant), 32'd0);
      wait_grant(10, gid);
      check_eq("sto_next_id", 32'(grant_id), 32'd2);

      // Hold timeout
      do_reset();
      req = 4'b0001;
      step();
      ut = 1'b1;
      step();
      k = 0;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (timeout) begin k = i; break; end
      end
      check_eq("hto_delay", 32'(k), 32'(HOLD_LIM));
      req = '1;
      step();
      check_eq("hto_clear", 32'(m_grant), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         check_eq("hto_no_regrant", 32'(m_grant), 32'd0);
      end

      // Slave-busy blocking and withdrawal
      do_reset();
      sb = 1'b1; req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("blocked", 32'(m_grant), 32'd0);
      end
      sb = 1'b0;
      step();
      check_eq("unblocked", 32'(m_grant), 32'b0001);
      req = '0;
      step();
      check_eq("withdraw_drop", 32'(m_grant), 32'd0);
      check_eq("withdraw_no_to", 32'(timeout), 32'd0);
      step();
      check_eq("withdraw_idle", 32'(arb_busy), 32'd0);

      // Asynchronous reset while BUSY
      do_reset();
      req = 4'b0100;
      step();
      ut = 1'b1;
      step(); step(); step();
      #2 rstn = 1'b0;
      #1;
      check_eq("arst_grant", 32'(m_grant),  32'd0);
      check_eq("arst_busy",  32'(arb_busy), 32'd0);
      ut = 1'b0; req = 4'b1010;
      step();
      rstn = 1'b1;
      step();
      check_eq("arst_first_id", 32'(grant_id), 32'd1);

      // Randomized traffic
      do_reset();
      for (int s = 0; s < 40; s++) begin
         mode = int'($urandom_range(0, 3));
         len  = (mode == 3) ? 300 : int'($urandom_range(20, 80));
         for (int c = 0; c < len; c++) begin
            rstn = 1'b1;
            case (mode)
               0: begin
                  req  = N'($urandom);
                  ut   = ($urandom_range(0, 3) == 0);
                  sb   = ($urandom_range(0, 4) == 0);
                  rstn = ($urandom_range(0, 99) != 0);
               end
               1: begin
                  req = N'($urandom);
                  sb  = ($urandom_range(0, 7) == 0);
                  ut  = (owner >= 0) && ($urandom_range(0, 3) != 0);
               end
               2: begin
                  req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
                  ut  = 1'b0;
                  sb  = 1'b0;
               end
               default: begin
                  req = '1;
                  ut  = 1'b1;
                  sb  = 1'b0;
               end
            endcase
            step();
         end
         ut = 1'b0; sb = 1'b0; rstn = 1'b1;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter that shares the single serial bus (b_BUS / b_RW / b_bus_utilizing) between up to NUM_MASTERS master modules.
- Takes one request line per master and returns one-hot grants. Tracks the granted master's bus tenure via b_bus_utilizing.
- Watchdog timeouts recover the bus from masters that stall.
- Replaces the fixed arbiter stub (arbiter_drive/arb_out) at top level and supplies each master's b_grant.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- ID_WIDTH, 2, width of granted-master index; must satisfy 2^ID_WIDTH >= NUM_MASTERS.
- START_TO_LEN, 4, width of the grant-to-start watchdog; limit is 2^START_TO_LEN-1 clocks.
- HOLD_TO_LEN, 8, width of the bus-hold watchdog; limit is 2^HOLD_TO_LEN-1 clocks.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- m_request  in  NUM_MASTERS  per-master request (b_request of each master), level.
- b_bus_utilizing  in  1  shared bus-in-use line, high while the granted master transacts.
- slv_bsy  in  1  shared slave-busy line; high blocks a new grant.
- m_grant  out  NUM_MASTERS  one-hot grant (b_grant of each master).
- grant_id  out  ID_WIDTH  index of the current or last granted master.
- arb_busy  out  1  high whenever the arbiter is not in IDLE.
- timeout  out  1  one-cycle pulse when either watchdog fires.

Behaviour:
- Reset (rstn low, asynchronous):
  - m_grant=0, grant_id=0, arb_busy=0, timeout=0, state=IDLE, watchdog counter=0.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 has first priority.
- States: IDLE, WAIT_START, BUSY, RELEASE.
- IDLE:
  - Grant only if |m_request, slv_bsy=0 and b_bus_utilizing=0.
  - Winner is the first requester searching from index last+1 upward, wrapping modulo NUM_MASTERS.
  - Next edge: m_grant[winner]=1, grant_id=winner, counter=0, state=WAIT_START. Latency request->grant is 1 clock.
  - If b_bus_utilizing or slv_bsy is high, stay in IDLE (foreign use or busy slave); requests wait.
- WAIT_START:
  - Grant held; counter increments each clock.
  - b_bus_utilizing=1 -> BUSY, counter=0.
  - Granted master's request drops while b_bus_utilizing=0 -> RELEASE (request withdrawn).
  - Counter reaches 2^START_TO_LEN-1 with no utilizing -> timeout=1 for one cycle, then RELEASE.
  - Priority when events coincide: utilizing > withdrawal > timeout.
- BUSY:
  - Grant held; counter increments each clock.
  - b_bus_utilizing falls -> RELEASE.
  - Counter reaches 2^HOLD_TO_LEN-1 -> timeout pulse, then RELEASE.
  - Changes on other masters' requests are ignored.
- RELEASE:
  - m_grant=0 for exactly one clock (bus turnaround); last=grant_id, then IDLE.
  - Re-grant is possible on the edge after returning to IDLE, so there are at least 2 clocks between grants.
  - The same master is re-granted only if no other master requests.
- Request bits of non-granted masters are sampled only in IDLE.
- grant_id holds its value outside grants.
- m_grant is at most one-hot in all states.
- Out-of-range request bits (index >= NUM_MASTERS) do not exist.
- Reset mid-transaction: grant drops immediately (asynchronous), state IDLE, pointer reset to NUM_MASTERS-1.
- arb_busy = (state != IDLE), registered.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Single requester: after reset, raise m_request=4'b0100; m_grant=4'b0100 and grant_id=2 one clock later. Drive utilizing high 10 clocks then low. Required: grant drops 1 clock after the fall, arb_busy low 1 clock after that.
- Round-robin fairness: hold m_request=4'b1111 and complete a short transaction on each grant. Required: grant order is 0,1,2,3,0, and each new grant comes at least 2 clocks after the previous release.
- Start timeout: grant master 1 and never assert utilizing. Required: timeout pulses exactly once, 15 clocks after grant (START_TO_LEN=4), grant cleared the next clock, and the next grant goes to master 2 if it is requesting.
- Hold timeout: utilizing held high indefinitely after grant. Required: timeout pulses at clock 255 of BUSY, grant drops, and no new grant is issued while utilizing stays high.
- Blocking: slv_bsy=1 with m_request=4'b0001. Required: no grant while slv_bsy is high; grant to master 0 one clock after slv_bsy falls. Withdraw the request in WAIT_START -> RELEASE, with no timeout pulse.
- Async reset in BUSY: drop rstn mid-edge. Required: m_grant=0 and arb_busy=0 immediately. After release with m_request=4'b1010, the first grant goes to master 1 (pointer reset).
